// File: rtl/bif_dpath_pkg.sv
// ---------------------------------------------------------------------------
// bif_dpath_pkg
// Shared definitions for the BIF datapath local-bus address (LBD) queue.
//   - Default widths and depth for the queue.
//   - lbd_entry_t : packed {ppn, ca} capture at the default widths.
//   - lbd_odd_par : per-byte odd parity over a zero-extended address word.
// No ports (package).
// ---------------------------------------------------------------------------
package bif_dpath_pkg;

    localparam int PPN_W_DEF = 14;
    localparam int CA_W_DEF  = 10;
    localparam int DEPTH_DEF = 4;

    // Widest LBD word the parity helper handles; callers zero-extend into it.
    localparam int LBD_MAX_W = 64;
    localparam int PAR_MAX_W = LBD_MAX_W / 8;

    typedef struct packed {
        logic [PPN_W_DEF-1:0] ppn;
        logic [CA_W_DEF-1:0]  ca;
    } lbd_entry_t;

    // Bit i is set when byte i holds an even number of ones, making the
    // byte plus its parity bit odd overall.
    function automatic logic [PAR_MAX_W-1:0] lbd_odd_par(input logic [LBD_MAX_W-1:0] data);
        logic [PAR_MAX_W-1:0] par;
        par = '0;
        for (int i = 0; i < PAR_MAX_W; i++) begin
            par[i] = ~^data[8*i +: 8];
        end
        return par;
    endfunction

endpackage

// File: rtl/bif_lbd_queue_mem.sv
// ---------------------------------------------------------------------------
// bif_lbd_queue_mem
// DEPTH x WIDTH register file for the LBD queue: one synchronous write port,
// one asynchronous read port. Contents are never reset; the owning queue's
// empty flag masks stale data.
// Ports:
//   clk    in   1        write clock
//   we     in   1        write enable
//   waddr  in   AW       write address
//   wdata  in   WIDTH    write data
//   raddr  in   AW       read address
//   rdata  out  WIDTH    read data (combinational)
// ---------------------------------------------------------------------------
module bif_lbd_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bif_dpath_lbd_addr_queue.sv
// ---------------------------------------------------------------------------
// bif_dpath_lbd_addr_queue
// BIF datapath local-bus address queue. Captures {ppn, ca} on every cycle
// ecreq is high and presents the oldest entry on lbd while eadr_n is low.
// The bus side retires the head with lbd_pop. A push into a full queue is
// dropped and latches the sticky ovf flag.
// Optional feature macro: BIF_LBD_PARITY_EN -- stores per-byte odd parity
// with each entry and drives it on lbd_par (otherwise lbd_par is 0).
// Ports:
//   sysclk   in   1        clock
//   sys_rst  in   1        synchronous reset, active-high
//   ppn      in   PPN_W    physical page number to capture
//   ca       in   CA_W     cache address to capture
//   ecreq    in   1        push request
//   eadr_n   in   1        output enable, active-low
//   lbd_pop  in   1        pop request
//   ovf_clr  in   1        clear sticky overflow
//   lbd      out  LBD_W    head entry, 0 when disabled or empty
//   lbd_oe   out  1        !eadr_n && !empty
//   lbd_par  out  LBD_W/8  per-byte odd parity of lbd
//   empty    out  1        queue empty
//   full     out  1        queue full
//   count    out  CNT_W    occupied entries
//   ovf      out  1        sticky overflow
// ---------------------------------------------------------------------------
module bif_dpath_lbd_addr_queue
    import bif_dpath_pkg::*;
#(
    parameter int PPN_W = PPN_W_DEF,
    parameter int CA_W  = CA_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int LBD_W = PPN_W + CA_W,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               sysclk,
    input  logic               sys_rst,
    input  logic [PPN_W-1:0]   ppn,
    input  logic [CA_W-1:0]    ca,
    input  logic               ecreq,
    input  logic               eadr_n,
    input  logic               lbd_pop,
    input  logic               ovf_clr,
    output logic [LBD_W-1:0]   lbd,
    output logic               lbd_oe,
    output logic [LBD_W/8-1:0] lbd_par,
    output logic               empty,
    output logic               full,
    output logic [CNT_W-1:0]   count,
    output logic               ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int PAR_W = LBD_W / 8;
`ifdef BIF_LBD_PARITY_EN
    localparam int MEM_W = LBD_W + PAR_W;
`else
    localparam int MEM_W = LBD_W;
`endif

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("bif_dpath_lbd_addr_queue: DEPTH must be a power of two >= 2");
    end
`ifdef BIF_LBD_PARITY_EN
    if (LBD_W % 8 != 0 || LBD_W > LBD_MAX_W) begin : g_bad_par_w
        $error("bif_dpath_lbd_addr_queue: parity needs LBD_W a multiple of 8 and <= 64");
    end
`endif

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;
    logic             push_ok;
    logic [LBD_W-1:0] entry;
    logic [MEM_W-1:0] wdata;
    logic [MEM_W-1:0] rdata;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = lbd_pop && !empty;
    // A same-cycle pop frees the slot, so a full queue still accepts the push.
    assign push_ok = ecreq && (!full || pop_ok);
    assign entry   = {ppn, ca};

`ifdef BIF_LBD_PARITY_EN
    logic [PAR_MAX_W-1:0] par_all;
    assign par_all = lbd_odd_par(LBD_MAX_W'(entry));
    assign wdata   = {par_all[PAR_W-1:0], entry};
`else
    assign wdata   = entry;
`endif

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
            // Overflow set takes priority over a same-cycle clear.
            if (ecreq && !push_ok) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    bif_lbd_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (MEM_W),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (sysclk),
        .we    (push_ok && !sys_rst),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign lbd_oe = !eadr_n && !empty;
    assign lbd    = lbd_oe ? rdata[LBD_W-1:0] : '0;

`ifdef BIF_LBD_PARITY_EN
    assign lbd_par = lbd_oe ? rdata[MEM_W-1:LBD_W] : '0;
`else
    assign lbd_par = '0;
`endif

endmodule

// File: tb/tb_bif_dpath_lbd_addr_queue.sv
// ---------------------------------------------------------------------------
// tb_bif_dpath_lbd_addr_queue
// Directed bench for bif_dpath_lbd_addr_queue at default parameters
// (PPN_W=14, CA_W=10, DEPTH=4). Inputs change 1 time unit after each rising
// edge; outputs are observed at that point or after a further 1 unit settle.
// ---------------------------------------------------------------------------
module tb_bif_dpath_lbd_addr_queue;

    logic        sysclk = 1'b0;
    logic        sys_rst;
    logic [13:0] ppn;
    logic [9:0]  ca;
    logic        ecreq;
    logic        eadr_n;
    logic        lbd_pop;
    logic        ovf_clr;
    logic [23:0] lbd;
    logic        lbd_oe;
    logic [2:0]  lbd_par;
    logic        empty;
    logic        full;
    logic [2:0]  count;
    logic        ovf;

    int nchk = 0;
    int nerr = 0;

    logic [23:0] model_q[$];
    logic [13:0] ppn_v [4] = '{14'h0001, 14'h3FFF, 14'h1234, 14'h2000};
    logic [9:0]  ca_v  [4] = '{10'h3FF, 10'h000, 10'h2AA, 10'h001};
    logic [23:0] exp_v;

    bif_dpath_lbd_addr_queue dut (
        .sysclk  (sysclk),
        .sys_rst (sys_rst),
        .ppn     (ppn),
        .ca      (ca),
        .ecreq   (ecreq),
        .eadr_n  (eadr_n),
        .lbd_pop (lbd_pop),
        .ovf_clr (ovf_clr),
        .lbd     (lbd),
        .lbd_oe  (lbd_oe),
        .lbd_par (lbd_par),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .ovf     (ovf)
    );

    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic [13:0] p, input logic [9:0] c);
        ppn = p; ca = c; ecreq = 1'b1;
        tick();
        ecreq = 1'b0;
    endtask

    task automatic pop_one();
        lbd_pop = 1'b1;
        tick();
        lbd_pop = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b1; ppn = '0; ca = '0; ecreq = 1'b0;
        eadr_n = 1'b1; lbd_pop = 1'b0; ovf_clr = 1'b0;
        tick();
        tick();
        sys_rst = 1'b0;
        eadr_n  = 1'b0;
        #1;

        // 1: reset then idle
        chk("rst_lbd",   lbd,    24'h0);
        chk("rst_oe",    lbd_oe, 1'b0);
        chk("rst_empty", empty,  1'b1);
        chk("rst_full",  full,   1'b0);
        chk("rst_count", count,  3'd0);
        chk("rst_ovf",   ovf,    1'b0);
        chk("rst_par",   lbd_par, 3'b000);

        // 2: single capture, then output enable off
        push_one(14'h2ABC, 10'h155);
        chk("t2_lbd",   lbd,    24'hAAF155);
        chk("t2_oe",    lbd_oe, 1'b1);
        chk("t2_count", count,  3'd1);
        eadr_n = 1'b1;
        #1;
        chk("t2_lbd_dis", lbd,    24'h0);
        chk("t2_oe_dis",  lbd_oe, 1'b0);
        tick();
        chk("t2_count_hold", count, 3'd1);
        eadr_n = 1'b0;
        pop_one();
        chk("t2_empty", empty, 1'b1);

        // 3: fill, overflow, ovf set/clear, drain in order
        for (int i = 0; i < 4; i++) push_one(ppn_v[i], ca_v[i]);
        chk("t3_full",  full,  1'b1);
        chk("t3_count", count, 3'd4);
        push_one(14'h0F0F, 10'h0F0);
        chk("t3_ovf",        ovf,   1'b1);
        chk("t3_count_drop", count, 3'd4);
        exp_v = {ppn_v[0], ca_v[0]};
        chk("t3_head_drop",  lbd,   exp_v);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", ovf, 1'b0);
        ecreq = 1'b1; ovf_clr = 1'b1;
        tick();
        ecreq = 1'b0; ovf_clr = 1'b0;
        chk("t3_ovf_set_wins", ovf, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_v = {ppn_v[i], ca_v[i]};
            chk($sformatf("t3_pop%0d", i), lbd, exp_v);
            pop_one();
        end
        chk("t3_empty", empty, 1'b1);
        chk("t3_lbd0",  lbd,   24'h0);
        chk("t3_oe0",   lbd_oe, 1'b0);
        lbd_pop = 1'b1;
        tick();
        lbd_pop = 1'b0;
        chk("t3_pop_empty_count", count, 3'd0);

        // 4: push+pop while full, then push+pop while empty
        for (int i = 0; i < 4; i++) push_one(ppn_v[i], ca_v[i]);
        ppn = 14'h1111; ca = 10'h222; ecreq = 1'b1; lbd_pop = 1'b1;
        tick();
        ecreq = 1'b0; lbd_pop = 1'b0;
        chk("t4_count_full_pp", count, 3'd4);
        chk("t4_ovf_none",      ovf,   1'b0);
        for (int i = 1; i < 4; i++) begin
            exp_v = {ppn_v[i], ca_v[i]};
            chk($sformatf("t4_pop%0d", i), lbd, exp_v);
            pop_one();
        end
        chk("t4_tail", lbd, {14'h1111, 10'h222});
        pop_one();
        chk("t4_empty", empty, 1'b1);
        ppn = 14'h0ACE; ca = 10'h1F1; ecreq = 1'b1; lbd_pop = 1'b1;
        tick();
        ecreq = 1'b0; lbd_pop = 1'b0;
        chk("t4_count_empty_pp", count, 3'd1);
        chk("t4_lbd_empty_pp",   lbd,   {14'h0ACE, 10'h1F1});
        pop_one();

        // 5: wrap with two entries resident, then reset mid-stream
        model_q.delete();
        for (int i = 0; i < 2; i++) begin
            push_one(14'(i + 16'h0100), 10'(i + 7));
            model_q.push_back({14'(i + 16'h0100), 10'(i + 7)});
        end
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t5_head%0d", i), lbd, model_q[0]);
            ppn = 14'(16'h2000 + i * 3); ca = 10'(i * 37 + 1);
            ecreq = 1'b1; lbd_pop = 1'b1;
            tick();
            ecreq = 1'b0; lbd_pop = 1'b0;
            model_q.push_back({14'(16'h2000 + i * 3), 10'(i * 37 + 1)});
            void'(model_q.pop_front());
            chk($sformatf("t5_count%0d", i), count, 3'd2);
        end
        chk("t5_head_end", lbd, model_q[0]);
        push_one(14'h0001, 10'h001);
        push_one(14'h0002, 10'h002);
        push_one(14'h0003, 10'h003);
        chk("t5_ovf_pre", ovf, 1'b1);
        sys_rst = 1'b1; ecreq = 1'b1; lbd_pop = 1'b1;
        tick();
        sys_rst = 1'b0; ecreq = 1'b0; lbd_pop = 1'b0;
        chk("t5_rst_count", count, 3'd0);
        chk("t5_rst_lbd",   lbd,   24'h0);
        chk("t5_rst_ovf",   ovf,   1'b0);
        chk("t5_rst_empty", empty, 1'b1);
        chk("t5_rst_full",  full,  1'b0);

        // 6: parity
        push_one(14'h0000, 10'h001);
        chk("t6_lbd", lbd, 24'h000001);
`ifdef BIF_LBD_PARITY_EN
        chk("t6_par", lbd_par, 3'b110);
`else
        chk("t6_par", lbd_par, 3'b000);
`endif
        eadr_n = 1'b1;
        #1;
        chk("t6_par_dis", lbd_par, 3'b000);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
